// File: rtl/serial_arith_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_ctrl
// Description : Bit-serial W-bit add/subtract/increment unit, LSB first,
//               one full-adder slice per clock, with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_arith_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] g,
    output logic         co
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] c_last_bit = CW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [1:0]    r_sel;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_sr;

    logic w_abit;
    logic w_bbit;
    logic w_x;
    logic w_y;
    logic w_sum;
    logic w_cout;
    logic w_last;

    // Full-adder slice; sel chooses which operand bits get inverted or zeroed
    always_comb begin
        w_abit = r_a[r_cnt];
        w_bbit = r_b[r_cnt];
        w_x    = (r_sel == 2'b11) ? ~w_abit : w_abit;
        case (r_sel)
            2'b00:   w_y = 1'b0;
            2'b10:   w_y = ~w_bbit;
            default: w_y = w_bbit;
        endcase
        w_sum  = w_x ^ w_y ^ r_carry;
        w_cout = (w_x & w_y) | (w_x & r_carry) | (w_y & r_carry);
        w_last = (r_cnt == c_last_bit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= 2'b00;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sr    <= '0;
            g       <= '0;
            co      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sel   <= sel;
                        r_carry <= ci;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sr    <= {w_sum, r_sr[W-1:1]};
                    r_carry <= w_cout;
                    // Counter holds on the final bit so it never wraps mid-operation
                    if (w_last) begin
                        g  <= {w_sum, r_sr[W-1:1]};
                        co <= w_cout;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_arith_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_arith_ctrl
// Description : Directed self-checking bench for serial_arith_ctrl (W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_arith_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       busy;
    logic       done;
    logic [7:0] g;
    logic       co;

    int n_cmp;
    int n_err;

    serial_arith_ctrl #(.W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sel   (sel),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .g     (g),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation from IDLE and wait (bounded) for done
    task automatic run_op(input logic [1:0] s, input logic [7:0] av, input logic [7:0] bv,
                          input logic c, output int lat, output int nbusy);
        sel   = s;
        a     = av;
        b     = bv;
        ci    = c;
        start = 1'b1;
        step();
        start = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        sel   = 2'b01;
        a     = 8'hAA;
        b     = 8'h55;
        ci    = 1'b1;
        step();
        step();
        n_cmp++;
        if ({busy, done, g, co} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b g=%h co=%b, want all 0", busy, done, g, co);
        end
        start = 1'b0;
        rst   = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_add();
        int lat, nb;
        run_op(2'b01, 8'h5A, 8'h33, 1'b0, lat, nb);
        n_cmp++;
        if (lat !== 8) begin
            n_err++;
            $display("FAIL add_latency: %0d edges, want 8", lat);
        end
        n_cmp++;
        if (nb !== 8) begin
            n_err++;
            $display("FAIL add_busy_cycles: %0d, want 8", nb);
        end
        n_cmp++;
        if (g !== 8'h8D || co !== 1'b0) begin
            n_err++;
            $display("FAIL add_result: g=%h co=%b, want g=8d co=0", g, co);
        end
        step();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || g !== 8'h8D) begin
            n_err++;
            $display("FAIL add_hold: done=%b busy=%b g=%h, want 0 0 8d", done, busy, g);
        end
    endtask

    task automatic test_subtract();
        int lat, nb;
        run_op(2'b10, 8'h10, 8'h01, 1'b1, lat, nb);
        n_cmp++;
        if (lat !== 8 || g !== 8'h0F || co !== 1'b1) begin
            n_err++;
            $display("FAIL sub_a_minus_b: lat=%0d g=%h co=%b, want 8 0f 1", lat, g, co);
        end
        step();
        run_op(2'b11, 8'h01, 8'h00, 1'b1, lat, nb);
        n_cmp++;
        if (lat !== 8 || g !== 8'hFF || co !== 1'b0) begin
            n_err++;
            $display("FAIL sub_b_minus_a: lat=%0d g=%h co=%b, want 8 ff 0", lat, g, co);
        end
        step();
    endtask

    task automatic test_increment();
        int lat, nb;
        run_op(2'b00, 8'hFF, 8'hA5, 1'b1, lat, nb);
        n_cmp++;
        if (lat !== 8 || g !== 8'h00 || co !== 1'b1) begin
            n_err++;
            $display("FAIL inc_wrap: lat=%0d g=%h co=%b, want 8 00 1", lat, g, co);
        end
        step();
    endtask

    task automatic test_hazard();
        int ndone, nbusy_after;
        sel   = 2'b01;
        a     = 8'h01;
        b     = 8'h01;
        ci    = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        sel   = 2'b11;
        step();
        start = 1'b0;
        ndone = 0;
        nbusy_after = 0;
        for (int i = 0; i < 25; i++) begin
            if (done) begin
                ndone++;
                n_cmp++;
                if (g !== 8'h02 || co !== 1'b0) begin
                    n_err++;
                    $display("FAIL hazard_result: g=%h co=%b, want 02 0", g, co);
                end
            end
            if (ndone > 0 && busy) nbusy_after++;
            step();
        end
        n_cmp++;
        if (ndone !== 1 || nbusy_after !== 0) begin
            n_err++;
            $display("FAIL hazard_single_op: done pulses=%0d busy-after=%0d, want 1 0", ndone, nbusy_after);
        end
    endtask

    task automatic test_reset_midop();
        int lat, nb, ndone;
        sel   = 2'b01;
        a     = 8'h5A;
        b     = 8'h33;
        ci    = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || g !== 8'h00 || co !== 1'b0) begin
            n_err++;
            $display("FAIL rst_midop: busy=%b done=%b g=%h co=%b, want 0 0 00 0", busy, done, g, co);
        end
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) ndone++;
            step();
        end
        n_cmp++;
        if (ndone !== 0) begin
            n_err++;
            $display("FAIL rst_no_done: %0d active cycles after abort, want 0", ndone);
        end
        run_op(2'b01, 8'h7F, 8'h01, 1'b0, lat, nb);
        n_cmp++;
        if (lat !== 8 || g !== 8'h80 || co !== 1'b0) begin
            n_err++;
            $display("FAIL rst_restart: lat=%0d g=%h co=%b, want 8 80 0", lat, g, co);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc, last_acc, nacc, ndone;
        logic prev_busy;
        sel       = 2'b10;
        a         = 8'h34;
        b         = 8'h12;
        ci        = 1'b1;
        start     = 1'b1;
        prev_busy = busy;
        last_acc  = -1;
        nacc      = 0;
        ndone     = 0;
        for (cyc = 1; cyc <= 35; cyc++) begin
            step();
            if (busy && !prev_busy) begin
                if (last_acc >= 0) begin
                    n_cmp++;
                    if (cyc - last_acc !== 10) begin
                        n_err++;
                        $display("FAIL b2b_spacing: %0d cycles, want 10", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                nacc++;
            end
            if (done) begin
                ndone++;
                n_cmp++;
                if (g !== 8'h22 || co !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_result: g=%h co=%b, want 22 1", g, co);
                end
            end
            prev_busy = busy;
        end
        start = 1'b0;
        n_cmp++;
        if (nacc !== 4 || ndone !== 3) begin
            n_err++;
            $display("FAIL b2b_count: accepts=%0d dones=%0d, want 4 3", nacc, ndone);
        end
        for (int i = 0; i < 15; i++) step();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        start = 1'b0;
        sel   = 2'b00;
        a     = 8'h00;
        b     = 8'h00;
        ci    = 1'b0;
        #1;
        test_reset();
        test_add();
        test_subtract();
        test_increment();
        test_hazard();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_arith_ctrl.md
SERIAL_ARITH_CTRL -- requirements
Module: serial_arith_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the operand width in bits; legal values are W >= 2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request to begin one operation; sampled only in IDLE.
REQ-005 sel  input  2  operation select, captured on accept.
REQ-006 a  input  W  operand A, captured on accept.
REQ-007 b  input  W  operand B, captured on accept.
REQ-008 ci  input  1  carry-in to bit 0, captured on accept.
REQ-009 busy  output  1  high while an operation is in RUN.
REQ-010 done  output  1  one-cycle pulse marking that g and co are valid.
REQ-011 g  output  W  registered result.
REQ-012 co  output  1  registered carry-out of bit W-1.

Function
REQ-013 The block SHALL compute a W-bit result bit-serially, LSB first, one bit per clock, using one 1-bit full-adder slice per cycle.
REQ-014 The per-bit slice operands SHALL be, by sel, with c = the running carry:
- 00: a[i] + c + 0 (increment by ci)
- 01: a[i] + b[i] + c (add)
- 10: a[i] + ~b[i] + c (subtract when ci=1)
- 11: ~a[i] + b[i] + c (b-a when ci=1)
REQ-015 The slice SHALL produce sum = x^y^z and carry = majority(x,y,z).
REQ-016 The FSM SHALL have states IDLE, RUN and DONE.
REQ-017 IDLE->RUN: on an edge with start=1, the block SHALL latch a, b, sel and ci into internal registers, set the running carry to ci and clear the bit counter to 0.
REQ-018 RUN: each edge SHALL process bit cnt, shift its sum into an internal result shift register, set carry <= slice carry and increment cnt.
REQ-019 RUN->DONE: on the edge that processes bit W-1, the block SHALL load g with the full result and co with the final carry.
REQ-020 DONE->IDLE: this transition SHALL occur unconditionally on the next edge.
REQ-021 busy SHALL be 1 exactly in RUN, for W cycles; done SHALL be 1 exactly in DONE, for 1 cycle.
REQ-022 Latency: done SHALL be high in the cycle following the W-th edge after the edge that accepted start; throughput is one operation per W+2 cycles.
REQ-023 start SHALL be ignored in RUN and DONE; no queuing, no error indication.
REQ-024 Changes on a, b, sel or ci after accept SHALL NOT affect the operation in flight.
REQ-025 g and co SHALL hold their last values from the DONE load until the next DONE load or reset.
REQ-026 The bit counter SHALL be ceil(log2 W) bits wide, SHALL NOT wrap within an operation, and SHALL be cleared on accept.
REQ-027 The internal slice SHALL be purely combinational; the only sequential elements are the FSM, cnt, the carry, the operand/select latches, the result shift register, g and co.

Reset
REQ-028 With rst=1 on an edge, the block SHALL enter IDLE and clear busy, done, g, co, cnt, the carry and all latches to 0.
REQ-029 rst SHALL take priority over start and over all state transitions.
REQ-030 rst in RUN or DONE SHALL abort the operation with no done pulse; the first start after rst is deasserted SHALL be accepted normally.

Verification (W=8)
REQ-031 Add: sel=01, a=0x5A, b=0x33, ci=0 -> done exactly 8 edges after the accept edge, g=0x8D, co=0, busy high for 8 cycles.
REQ-032 Subtract: sel=10, a=0x10, b=0x01, ci=1 -> g=0x0F, co=1; then sel=11, a=0x01, b=0x00, ci=1 -> g=0xFF, co=0.
REQ-033 Increment with wrap: sel=00, a=0xFF, b=0xA5, ci=1 -> g=0x00, co=1.
REQ-034 Hazard: accept add 0x01+0x01; during RUN, pulse start and change a to 0xFF, b to 0xFF and sel to 11 -> g=0x02, co=0, exactly one done pulse, no second operation started.
REQ-035 Reset mid-op: accept any operation, assert rst on the 4th RUN edge -> next cycle busy=0, done=0, g=0x00, co=0, and no done pulse; then add 0x7F+0x01, ci=0 -> g=0x80, co=0.
REQ-036 Back-to-back: hold start=1 continuously -> accepts occur every W+2 = 10 cycles, each with a correct result.
